// File: rtl/gs_ex_pipe_if.sv
// Execute-stage port bundle: upstream issue handshake, forwarding source,
// flush, and the downstream result handshake.
interface gs_ex_pipe_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 8
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [3:0]        op_i;
  logic              mul_i;
  logic              alu_src_i;
  logic              rd_src_i;
  logic [4:0]        rs1_addr_i;
  logic [4:0]        rs2_addr_i;
  logic [XLEN-1:0]   rs1_data_i;
  logic [XLEN-1:0]   rs2_data_i;
  logic [XLEN-1:0]   imm_i;
  logic [XLEN-1:0]   pc_link_i;
  logic [CTRL_W-1:0] ctrl_i;
  logic [4:0]        rd_addr_i;
  logic              fwd_valid_i;
  logic [4:0]        fwd_addr_i;
  logic [XLEN-1:0]   fwd_data_i;
  logic              flush_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [XLEN-1:0]   result_o;
  logic [XLEN-1:0]   store_data_o;
  logic              br_taken_o;
  logic [4:0]        rd_addr_o;
  logic [CTRL_W-1:0] ctrl_o;
  logic              busy_o;

  modport slave (
    input  in_valid_i, op_i, mul_i, alu_src_i, rd_src_i,
           rs1_addr_i, rs2_addr_i, rs1_data_i, rs2_data_i, imm_i, pc_link_i,
           ctrl_i, rd_addr_i, fwd_valid_i, fwd_addr_i, fwd_data_i, flush_i,
           out_ready_i,
    output in_ready_o, out_valid_o, result_o, store_data_o, br_taken_o,
           rd_addr_o, ctrl_o, busy_o
  );

  modport master (
    output in_valid_i, op_i, mul_i, alu_src_i, rd_src_i,
           rs1_addr_i, rs2_addr_i, rs1_data_i, rs2_data_i, imm_i, pc_link_i,
           ctrl_i, rd_addr_i, fwd_valid_i, fwd_addr_i, fwd_data_i, flush_i,
           out_ready_i,
    input  in_ready_o, out_valid_o, result_o, store_data_o, br_taken_o,
           rd_addr_o, ctrl_o, busy_o
  );
endinterface

// File: rtl/gs_ex_pipe.sv
// Execute stage: single-cycle ALU/branch compare plus an optional radix-2
// iterative multiplier, with operand forwarding on accept and flush support.
module gs_ex_pipe #(
  parameter int XLEN   = 32,
  parameter int MUL_EN = 1,
  parameter int CTRL_W = 8
) (
  input logic         clk,
  input logic         rst,
  gs_ex_pipe_if.slave bus
);
  localparam int SH_W = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
    OP_OR, OP_AND, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU
  } alu_op_t;

  state_t            state_q, state_d;
  logic [SH_W-1:0]   cnt_q;
  logic [XLEN-1:0]   op_a_q, rs2_q, imm_q, pc_link_q;
  logic [XLEN-1:0]   mcand_q, mplier_q, acc_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [4:0]        rd_addr_q;
  alu_op_t           op_q;
  logic              alu_src_q, rd_src_q, mul_q;

  logic              in_ready, accept, mul_go, cnt_last;
  logic [XLEN-1:0]   a_in, rs2_in, op_b, alu_res;
  logic [SH_W-1:0]   shamt;
  logic              br;

  // Accepting while DONE is legal when the held result drains the same cycle.
  assign in_ready = ~bus.flush_i &
                    ((state_q == IDLE) | ((state_q == DONE) & bus.out_ready_i));
  assign accept   = bus.in_valid_i & in_ready;
  assign mul_go   = (MUL_EN != 0) & bus.mul_i;
  assign cnt_last = (cnt_q == SH_W'(XLEN - 1));

  assign a_in   = (bus.fwd_valid_i && bus.fwd_addr_i == bus.rs1_addr_i &&
                   bus.rs1_addr_i != 5'd0) ? bus.fwd_data_i : bus.rs1_data_i;
  assign rs2_in = (bus.fwd_valid_i && bus.fwd_addr_i == bus.rs2_addr_i &&
                   bus.rs2_addr_i != 5'd0) ? bus.fwd_data_i : bus.rs2_data_i;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = mul_go ? MUL : DONE;
      MUL:     if (cnt_last) state_d = DONE;
      DONE:    if (bus.out_ready_i) state_d = accept ? (mul_go ? MUL : DONE) : IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == MUL && !bus.flush_i && !cnt_last) cnt_q <= cnt_q + 1'b1;
      else                                             cnt_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_a_q    <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
      pc_link_q <= '0;
      ctrl_q    <= '0;
      rd_addr_q <= '0;
      op_q      <= OP_ADD;
      alu_src_q <= 1'b0;
      rd_src_q  <= 1'b0;
      mul_q     <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
    end else if (accept) begin
      op_a_q    <= a_in;
      rs2_q     <= rs2_in;
      imm_q     <= bus.imm_i;
      pc_link_q <= bus.pc_link_i;
      ctrl_q    <= bus.ctrl_i;
      rd_addr_q <= bus.rd_addr_i;
      op_q      <= alu_op_t'(bus.op_i);
      alu_src_q <= bus.alu_src_i;
      rd_src_q  <= bus.rd_src_i;
      mul_q     <= mul_go;
      mcand_q   <= a_in;
      mplier_q  <= bus.alu_src_i ? bus.imm_i : rs2_in;
      acc_q     <= '0;
    end else if (state_q == MUL) begin
      // Shift-add: consume one multiplier bit per cycle, LSB first.
      if (mplier_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

  assign op_b  = alu_src_q ? imm_q : rs2_q;
  assign shamt = op_b[SH_W-1:0];

  always_comb begin
    alu_res = op_a_q + op_b;
    br      = 1'b0;
    unique case (op_q)
      OP_ADD:  alu_res = op_a_q + op_b;
      OP_SUB:  alu_res = op_a_q - op_b;
      OP_SLL:  alu_res = op_a_q << shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a_q) < $signed(op_b)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, op_a_q < op_b};
      OP_XOR:  alu_res = op_a_q ^ op_b;
      OP_SRL:  alu_res = op_a_q >> shamt;
      OP_SRA:  alu_res = $signed(op_a_q) >>> shamt;
      OP_OR:   alu_res = op_a_q | op_b;
      OP_AND:  alu_res = op_a_q & op_b;
      OP_BEQ:  br = (op_a_q == op_b);
      OP_BNE:  br = (op_a_q != op_b);
      OP_BLT:  br = ($signed(op_a_q) < $signed(op_b));
      OP_BGE:  br = ($signed(op_a_q) >= $signed(op_b));
      OP_BLTU: br = (op_a_q < op_b);
      OP_BGEU: br = (op_a_q >= op_b);
      default: br = 1'b0;
    endcase
  end

  assign bus.in_ready_o   = in_ready;
  assign bus.out_valid_o  = (state_q == DONE);
  assign bus.busy_o       = (state_q == MUL);
  assign bus.result_o     = rd_src_q ? pc_link_q : (mul_q ? acc_q : alu_res);
  assign bus.br_taken_o   = br & ~mul_q;
  assign bus.store_data_o = rs2_q;
  assign bus.rd_addr_o    = rd_addr_q;
  assign bus.ctrl_o       = ctrl_q;
endmodule

// File: tb/tb_gs_ex_pipe.sv
// Self-checking bench for gs_ex_pipe: vector table through a scoreboard,
// plus backpressure, flush and mid-multiply reset sequences.
module tb_gs_ex_pipe;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gs_ex_pipe_if #(.XLEN(32), .CTRL_W(8)) bus ();
  gs_ex_pipe #(.XLEN(32), .MUL_EN(1), .CTRL_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [3:0]  op;
    bit          mul, alu_src, rd_src;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1, rs2, imm, pc;
    bit          fwd_v;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;
    logic [31:0] exp_result;
    bit          exp_br;
    logic [31:0] exp_store;
    int          exp_wait;
  } vec_t;

  typedef struct {
    logic [31:0] result;
    bit          br;
    logic [4:0]  rd;
    logic [7:0]  ctrl;
    logic [31:0] store;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t alu_vec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] r, input bit br_exp);
    vec_t v;
    v.op = op; v.mul = 0; v.alu_src = 0; v.rd_src = 0;
    v.rs1_addr = 5'd1; v.rs2_addr = 5'd2; v.rs1 = a; v.rs2 = b; v.imm = '0; v.pc = '0;
    v.fwd_v = 0; v.fwd_addr = '0; v.fwd_data = '0;
    v.exp_result = r; v.exp_br = br_exp; v.exp_store = b; v.exp_wait = 0;
    return v;
  endfunction

  task automatic sb_pop();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_output: got result 0x%0h, expected no output", bus.result_o);
    end else begin
      e = sb_q.pop_front();
      check("result", bus.result_o, e.result);
      check("br_taken", bus.br_taken_o, e.br);
      check("rd_addr", bus.rd_addr_o, e.rd);
      check("ctrl", bus.ctrl_o, e.ctrl);
      check("store_data", bus.store_data_o, e.store);
    end
  endtask

  // Starts and ends on a negedge; drains any pending output in the same cycles.
  task automatic issue(input vec_t v, input logic [4:0] rd, input logic [7:0] ctrl,
                       input bit expect_out, output int tries);
    bit   acc = 0;
    exp_t e;
    tries = 0;
    bus.op_i = v.op; bus.mul_i = v.mul; bus.alu_src_i = v.alu_src; bus.rd_src_i = v.rd_src;
    bus.rs1_addr_i = v.rs1_addr; bus.rs2_addr_i = v.rs2_addr;
    bus.rs1_data_i = v.rs1; bus.rs2_data_i = v.rs2; bus.imm_i = v.imm; bus.pc_link_i = v.pc;
    bus.fwd_valid_i = v.fwd_v; bus.fwd_addr_i = v.fwd_addr; bus.fwd_data_i = v.fwd_data;
    bus.rd_addr_i = rd; bus.ctrl_i = ctrl; bus.in_valid_i = 1'b1;
    e = '{v.exp_result, v.exp_br, rd, ctrl, v.exp_store};
    while (!acc && tries < 100) begin
      #1;
      if (bus.out_valid_o && bus.out_ready_i) sb_pop();
      acc = bus.in_ready_o;
      if (acc && expect_out) sb_q.push_back(e);
      @(posedge clk); @(negedge clk);
      tries++;
    end
    bus.in_valid_i  = 1'b0;
    bus.fwd_valid_i = 1'b0;
    check("accepted", acc, 1);
  endtask

  task automatic wait_out(input int exp_wait);
    int waited = 0, busy_n = 0, rdy_n = 0;
    #1;
    while (!bus.out_valid_o && waited < 200) begin
      if (bus.busy_o) busy_n++;
      if (bus.in_ready_o) rdy_n++;
      @(posedge clk); @(negedge clk); #1;
      waited++;
    end
    check("latency", waited, exp_wait);
    if (exp_wait > 0) begin
      check("busy_cycles", busy_n, exp_wait);
      check("in_ready_while_busy", rdy_n, 0);
    end
    if (bus.out_valid_o && bus.out_ready_i) begin
      sb_pop();
      @(posedge clk); @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    vec_t v;
    int   tries;
    int   seen;

    tbl.push_back(alu_vec(4'd0,  32'h7FFFFFFF, 32'h1,        32'h80000000, 0));
    tbl.push_back(alu_vec(4'd1,  32'd5,        32'd7,        32'hFFFFFFFE, 0));
    tbl.push_back(alu_vec(4'd2,  32'h1,        32'h23,       32'h8,        0));
    tbl.push_back(alu_vec(4'd3,  32'hFFFFFFFF, 32'h1,        32'h1,        0));
    tbl.push_back(alu_vec(4'd4,  32'hFFFFFFFF, 32'h1,        32'h0,        0));
    tbl.push_back(alu_vec(4'd5,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0));
    tbl.push_back(alu_vec(4'd6,  32'h80000000, 32'h4,        32'h08000000, 0));
    tbl.push_back(alu_vec(4'd7,  32'h80000000, 32'h4,        32'hF8000000, 0));
    tbl.push_back(alu_vec(4'd8,  32'h0F00,     32'h00F0,     32'h0FF0,     0));
    tbl.push_back(alu_vec(4'd9,  32'hFF0F,     32'h0FFF,     32'h0F0F,     0));
    tbl.push_back(alu_vec(4'd10, 32'd5,        32'd5,        32'hA,        1));
    tbl.push_back(alu_vec(4'd11, 32'd5,        32'd5,        32'hA,        0));
    tbl.push_back(alu_vec(4'd12, 32'h1,        32'hFFFFFFFF, 32'h0,        0));
    tbl.push_back(alu_vec(4'd14, 32'h1,        32'hFFFFFFFF, 32'h0,        1));
    tbl.push_back(alu_vec(4'd13, 32'hFFFFFFFF, 32'h1,        32'h0,        0));
    tbl.push_back(alu_vec(4'd15, 32'hFFFFFFFF, 32'h1,        32'h0,        1));
    v = alu_vec(4'd0, 32'd100, 32'd55, 32'd99, 0); v.alu_src = 1; v.imm = 32'hFFFFFFFF;
    tbl.push_back(v);
    v = alu_vec(4'd0, 32'd1, 32'd2, 32'h1004, 0); v.rd_src = 1; v.pc = 32'h1004;
    tbl.push_back(v);
    v = alu_vec(4'd0, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD, 0); v.mul = 1; v.exp_wait = 32;
    tbl.push_back(v);
    v = alu_vec(4'd11, 32'h12345678, 32'h10, 32'h23456780, 0); v.mul = 1; v.exp_wait = 32;
    tbl.push_back(v);
    // Forwarding: rs1 hit, rs1 = x0 (no forward), rs2 hit, forward source not valid.
    v = alu_vec(4'd0, 32'd99, 32'd0, 32'd11, 0); v.alu_src = 1; v.imm = 32'd1;
    v.rs1_addr = 5'd5; v.fwd_v = 1; v.fwd_addr = 5'd5; v.fwd_data = 32'd10;
    tbl.push_back(v);
    v.rs1_addr = 5'd0; v.fwd_addr = 5'd0; v.exp_result = 32'd100;
    tbl.push_back(v);
    v = alu_vec(4'd0, 32'd1, 32'd3, 32'h78, 0); v.rs1_addr = 5'd3; v.rs2_addr = 5'd7;
    v.fwd_v = 1; v.fwd_addr = 5'd7; v.fwd_data = 32'h77; v.exp_store = 32'h77;
    tbl.push_back(v);
    v = alu_vec(4'd0, 32'd99, 32'd0, 32'd100, 0); v.alu_src = 1; v.imm = 32'd1;
    v.rs1_addr = 5'd5; v.fwd_v = 0; v.fwd_addr = 5'd5; v.fwd_data = 32'd10;
    tbl.push_back(v);

    bus.in_valid_i = 0; bus.op_i = '0; bus.mul_i = 0; bus.alu_src_i = 0; bus.rd_src_i = 0;
    bus.rs1_addr_i = '0; bus.rs2_addr_i = '0; bus.rs1_data_i = '0; bus.rs2_data_i = '0;
    bus.imm_i = '0; bus.pc_link_i = '0; bus.ctrl_i = '0; bus.rd_addr_i = '0;
    bus.fwd_valid_i = 0; bus.fwd_addr_i = '0; bus.fwd_data_i = '0; bus.flush_i = 0;
    bus.out_ready_i = 1;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", bus.out_valid_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_br_taken", bus.br_taken_o, 0);
    check("rst_result", bus.result_o, 0);
    check("rst_store_data", bus.store_data_o, 0);
    check("rst_rd_addr", bus.rd_addr_o, 0);
    check("rst_ctrl", bus.ctrl_o, 0);
    check("rst_in_ready", bus.in_ready_o, 1);
    @(negedge clk);
    rst = 1'b1;

    // Vector table through the scoreboard
    for (int i = 0; i < tbl.size(); i++) begin
      issue(tbl[i], 5'(i + 1), 8'(i * 13 + 1), 1, tries);
      wait_out(tbl[i].exp_wait);
    end

    // Backpressure: result held, then drain and accept back-to-back
    bus.out_ready_i = 0;
    issue(alu_vec(4'd0, 32'd2, 32'd3, 32'd5, 0), 5'd20, 8'hA5, 1, tries);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("hold_out_valid", bus.out_valid_o, 1);
      check("hold_result", bus.result_o, 32'd5);
      check("hold_in_ready", bus.in_ready_o, 0);
      @(posedge clk); @(negedge clk);
    end
    bus.out_ready_i = 1;
    issue(alu_vec(4'd0, 32'd10, 32'd20, 32'd30, 0), 5'd21, 8'h5A, 1, tries);
    check("b2b_tries", tries, 1);
    #1;
    check("b2b_no_bubble", bus.out_valid_o, 1);
    wait_out(0);

    // Flush at multiply cycle 10; the instruction offered during flush is dropped
    v = alu_vec(4'd0, 32'd7, 32'd9, 32'd63, 0); v.mul = 1;
    issue(v, 5'd9, 8'h11, 0, tries);
    repeat (9) begin @(posedge clk); @(negedge clk); end
    #1;
    check("busy_before_flush", bus.busy_o, 1);
    bus.flush_i = 1; bus.in_valid_i = 1; bus.mul_i = 0;
    #1;
    check("flush_in_ready", bus.in_ready_o, 0);
    @(posedge clk); @(negedge clk);
    bus.flush_i = 0; bus.in_valid_i = 0;
    #1;
    check("flush_busy", bus.busy_o, 0);
    check("flush_out_valid", bus.out_valid_o, 0);
    check("flush_in_ready_after", bus.in_ready_o, 1);
    seen = 0;
    repeat (40) begin
      @(posedge clk); @(negedge clk); #1;
      if (bus.out_valid_o || bus.busy_o) seen++;
    end
    check("flush_no_result", seen, 0);
    @(negedge clk);
    issue(alu_vec(4'd5, 32'hAAAA, 32'hFFFF, 32'h5555, 0), 5'd10, 8'h22, 1, tries);
    wait_out(0);

    // Flush of a held result in DONE
    bus.out_ready_i = 0;
    issue(alu_vec(4'd0, 32'd4, 32'd4, 32'd8, 0), 5'd11, 8'h33, 0, tries);
    #1;
    check("done_held", bus.out_valid_o, 1);
    bus.flush_i = 1;
    @(posedge clk); @(negedge clk);
    bus.flush_i = 0; bus.out_ready_i = 1;
    #1;
    check("done_flushed", bus.out_valid_o, 0);
    @(negedge clk);

    // Reset mid-multiply, then accept on the first edge after release
    v = alu_vec(4'd0, 32'd6, 32'd6, 32'd36, 0); v.mul = 1;
    issue(v, 5'd12, 8'h44, 0, tries);
    repeat (5) begin @(posedge clk); @(negedge clk); end
    #1;
    check("busy_before_rst", bus.busy_o, 1);
    rst = 1'b0;
    #1;
    check("rst_abort_busy", bus.busy_o, 0);
    check("rst_abort_out_valid", bus.out_valid_o, 0);
    check("rst_abort_result", bus.result_o, 0);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    issue(alu_vec(4'd8, 32'h100, 32'h3, 32'h103, 0), 5'd13, 8'h55, 1, tries);
    check("post_rst_tries", tries, 1);
    wait_out(0);

    check("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
